// File: rtl/second_chance_pkg.sv
// Shared types and constants for the second-chance slot allocator.
package second_chance_pkg;

  typedef enum logic {
    OP_INSERT = 1'b0,
    OP_DELETE = 1'b1
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_CHK  = 2'd2,
    ST_RSP  = 2'd3
  } state_t;

  localparam logic [1:0] SEL_NONE = 2'd3;

endpackage

// File: rtl/second_chance_slot_allocator_if.sv
// Request, flag-register and response signals of the slot allocator.
interface second_chance_slot_allocator_if #(parameter int SIZE = 10);
  logic            req_valid;
  logic            req_ready;
  logic            req_op;
  logic [SIZE-1:0] req_adr_0;
  logic [SIZE-1:0] req_adr_1;
  logic [SIZE-1:0] req_adr_2;
  logic [SIZE-1:0] read_adr_0;
  logic [SIZE-1:0] read_adr_1;
  logic [SIZE-1:0] read_adr_2;
  logic            flag_in_0;
  logic            flag_in_1;
  logic            flag_in_2;
  logic [SIZE-1:0] write_adr;
  logic            write_en;
  logic            write_is_valid;
  logic            resp_valid;
  logic            resp_ready;
  logic            resp_ok;
  logic [1:0]      resp_sel;
  logic [SIZE-1:0] resp_adr;

  modport slave (
    input  req_valid, req_op, req_adr_0, req_adr_1, req_adr_2,
    input  flag_in_0, flag_in_1, flag_in_2, resp_ready,
    output req_ready, read_adr_0, read_adr_1, read_adr_2,
    output write_adr, write_en, write_is_valid,
    output resp_valid, resp_ok, resp_sel, resp_adr
  );

  modport master (
    output req_valid, req_op, req_adr_0, req_adr_1, req_adr_2,
    output flag_in_0, flag_in_1, flag_in_2, resp_ready,
    input  req_ready, read_adr_0, read_adr_1, read_adr_2,
    input  write_adr, write_en, write_is_valid,
    input  resp_valid, resp_ok, resp_sel, resp_adr
  );
endinterface

// File: rtl/second_chance_free_select.sv
// Three-way priority picker: lowest-index free candidate wins.
module second_chance_free_select
  import second_chance_pkg::*;
(
  input  logic [2:0] i_free,
  output logic       o_found,
  output logic [1:0] o_sel
);

  always_comb begin
    o_found = 1'b1;
    o_sel   = 2'd0;
    if (i_free[0]) begin
      o_sel = 2'd0;
    end else if (i_free[1]) begin
      o_sel = 2'd1;
    end else if (i_free[2]) begin
      o_sel = 2'd2;
    end else begin
      o_found = 1'b0;
      o_sel   = SEL_NONE;
    end
  end

endmodule

// File: rtl/second_chance_slot_allocator.sv
// Insert/delete control stage in front of the second-chance flag register.
// Optional occupancy/insert statistics under SLOT_ALLOC_STATS_EN.
module second_chance_slot_allocator
  import second_chance_pkg::*;
#(
  parameter int SIZE = 10
) (
  input  logic clk,
  input  logic reset,
  second_chance_slot_allocator_if.slave bus
`ifdef SLOT_ALLOC_STATS_EN
  ,
  output logic [31:0]   stat_inserts,
  output logic [31:0]   stat_fails,
  output logic [SIZE:0] stat_occupied
`endif
);

  state_t          r_state;
  state_t          w_next;
  op_t             r_op;
  logic [SIZE-1:0] r_adr_0;
  logic [SIZE-1:0] r_adr_1;
  logic [SIZE-1:0] r_adr_2;
  logic            r_resp_ok;
  logic [1:0]      r_resp_sel;
  logic [SIZE-1:0] r_resp_adr;

  logic            w_found;
  logic [1:0]      w_sel;
  logic [SIZE-1:0] w_win_adr;

  second_chance_free_select u_free_select (
    .i_free  (~{bus.flag_in_2, bus.flag_in_1, bus.flag_in_0}),
    .o_found (w_found),
    .o_sel   (w_sel)
  );

  // With no winner the address falls back to candidate 0.
  always_comb begin
    case (w_sel)
      2'd1:    w_win_adr = r_adr_1;
      2'd2:    w_win_adr = r_adr_2;
      default: w_win_adr = r_adr_0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Write strobe is gated by reset so a write pending in CHK is dropped.
  always_comb begin
    w_next             = r_state;
    bus.req_ready      = 1'b0;
    bus.resp_valid     = 1'b0;
    bus.write_en       = 1'b0;
    bus.write_adr      = r_adr_0;
    bus.write_is_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus.req_ready = !reset;
        if (bus.req_valid && !reset) w_next = ST_RD;
      end
      ST_RD:   w_next = ST_CHK;
      ST_CHK: begin
        w_next = ST_RSP;
        if (r_op == OP_DELETE) begin
          bus.write_en = !reset;
        end else if (w_found) begin
          bus.write_en       = !reset;
          bus.write_adr      = w_win_adr;
          bus.write_is_valid = 1'b1;
        end
      end
      ST_RSP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op       <= OP_INSERT;
      r_adr_0    <= '0;
      r_adr_1    <= '0;
      r_adr_2    <= '0;
      r_resp_ok  <= 1'b0;
      r_resp_sel <= SEL_NONE;
      r_resp_adr <= '0;
    end else begin
      if (r_state == ST_IDLE && bus.req_valid) begin
        r_op    <= op_t'(bus.req_op);
        r_adr_0 <= bus.req_adr_0;
        r_adr_1 <= bus.req_adr_1;
        r_adr_2 <= bus.req_adr_2;
      end
      if (r_state == ST_CHK) begin
        if (r_op == OP_DELETE) begin
          r_resp_ok  <= bus.flag_in_0;
          r_resp_sel <= 2'd0;
          r_resp_adr <= r_adr_0;
        end else begin
          r_resp_ok  <= w_found;
          r_resp_sel <= w_sel;
          r_resp_adr <= w_win_adr;
        end
      end
    end
  end

  assign bus.read_adr_0 = r_adr_0;
  assign bus.read_adr_1 = r_adr_1;
  assign bus.read_adr_2 = r_adr_2;
  assign bus.resp_ok    = r_resp_ok;
  assign bus.resp_sel   = r_resp_sel;
  assign bus.resp_adr   = r_resp_adr;

`ifdef SLOT_ALLOC_STATS_EN
  localparam logic [SIZE:0] OCC_MAX = {1'b1, {SIZE{1'b0}}};

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_inserts  <= '0;
      stat_fails    <= '0;
      stat_occupied <= '0;
    end else if (r_state == ST_CHK) begin
      if (r_op == OP_INSERT) begin
        if (w_found) begin
          stat_inserts <= stat_inserts + 32'd1;
          if (stat_occupied != OCC_MAX) stat_occupied <= stat_occupied + 1'b1;
        end else begin
          stat_fails <= stat_fails + 32'd1;
        end
      end else if (bus.flag_in_0 && stat_occupied != '0) begin
        stat_occupied <= stat_occupied - 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_second_chance_slot_allocator.sv
// Scoreboard bench for second_chance_slot_allocator with a behavioural flag register.
module tb_second_chance_slot_allocator;
  import second_chance_pkg::*;

  localparam int SIZE = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  second_chance_slot_allocator_if #(.SIZE(SIZE)) bus ();

`ifdef SLOT_ALLOC_STATS_EN
  logic [31:0]   stat_inserts;
  logic [31:0]   stat_fails;
  logic [SIZE:0] stat_occupied;
`endif

  second_chance_slot_allocator #(.SIZE(SIZE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
`ifdef SLOT_ALLOC_STATS_EN
    ,
    .stat_inserts  (stat_inserts),
    .stat_fails    (stat_fails),
    .stat_occupied (stat_occupied)
`endif
  );

  // Flag register model: registered reads, write lands on the clock edge.
  logic flags [0:(1<<SIZE)-1];
  initial for (int i = 0; i < (1 << SIZE); i++) flags[i] = 1'b0;
  always @(posedge clk) begin
    if (bus.write_en) flags[bus.write_adr] <= bus.write_is_valid;
    bus.flag_in_0 <= flags[bus.read_adr_0];
    bus.flag_in_1 <= flags[bus.read_adr_1];
    bus.flag_in_2 <= flags[bus.read_adr_2];
  end

  typedef struct {
    logic            ok;
    logic [1:0]      sel;
    logic [SIZE-1:0] adr;
  } resp_t;

  typedef struct {
    logic [SIZE-1:0] adr;
    logic            v;
  } wr_t;

  resp_t resp_q[$];
  wr_t   wr_q[$];
  int    n_pass = 0;
  int    n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (!reset && bus.resp_valid && bus.resp_ready) begin
      resp_t e;
      if (resp_q.size() == 0) begin
        chk("resp_unexpected", resp_q.size(), 32'd1);
      end else begin
        e = resp_q.pop_front();
        chk("resp_ok",  bus.resp_ok,  e.ok);
        chk("resp_sel", bus.resp_sel, e.sel);
        chk("resp_adr", bus.resp_adr, e.adr);
      end
    end
  end

  always @(negedge clk) begin
    if (bus.write_en) begin
      wr_t w;
      if (wr_q.size() == 0) begin
        chk("write_unexpected", wr_q.size(), 32'd1);
      end else begin
        w = wr_q.pop_front();
        chk("write_adr",      bus.write_adr,      w.adr);
        chk("write_is_valid", bus.write_is_valid, w.v);
      end
    end
  end

  task automatic issue(input logic op, input logic [SIZE-1:0] a0, a1, a2,
                       input logic wr_exp, input logic [SIZE-1:0] wa, input logic wv,
                       input logic rok, input logic [1:0] rsel, input logic [SIZE-1:0] radr);
    int    n;
    resp_t r;
    wr_t   w;
    r.ok = rok; r.sel = rsel; r.adr = radr;
    resp_q.push_back(r);
    if (wr_exp) begin
      w.adr = wa; w.v = wv;
      wr_q.push_back(w);
    end
    @(posedge clk); #1;
    bus.req_op = op; bus.req_adr_0 = a0; bus.req_adr_1 = a1; bus.req_adr_2 = a2;
    bus.req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) chk("req_ready_timeout", bus.req_ready, 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.resp_valid && n < 10);
    chk("latency", n, 32'd3);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) chk("idle_timeout", bus.req_ready, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_tot);
    $fatal(1, "timeout");
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_op     = 1'b0;
    bus.req_adr_0  = '0;
    bus.req_adr_1  = '0;
    bus.req_adr_2  = '0;
    bus.resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready",  bus.req_ready,  32'd0);
    chk("rst_resp_valid", bus.resp_valid, 32'd0);
    chk("rst_write_en",   bus.write_en,   32'd0);
    chk("rst_resp_sel",   bus.resp_sel,   32'd3);
    chk("rst_resp_adr",   bus.resp_adr,   32'd0);
    chk("rst_read_adr_0", bus.read_adr_0, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Fill 5, 9, 12 in priority order, then a full insert fails.
    issue(OP_INSERT, 10'd5, 10'd9, 10'd12, 1'b1, 10'd5,  1'b1, 1'b1, 2'd0, 10'd5);  wait_idle();
    issue(OP_INSERT, 10'd5, 10'd9, 10'd12, 1'b1, 10'd9,  1'b1, 1'b1, 2'd1, 10'd9);  wait_idle();
    issue(OP_INSERT, 10'd5, 10'd9, 10'd12, 1'b1, 10'd12, 1'b1, 1'b1, 2'd2, 10'd12); wait_idle();
    issue(OP_INSERT, 10'd5, 10'd9, 10'd12, 1'b0, 10'd0,  1'b0, 1'b0, 2'd3, 10'd5);  wait_idle();
    issue(OP_DELETE, 10'd9, 10'd0, 10'd0,  1'b1, 10'd9,  1'b0, 1'b1, 2'd0, 10'd9);  wait_idle();
    issue(OP_INSERT, 10'd5, 10'd9, 10'd12, 1'b1, 10'd9,  1'b1, 1'b1, 2'd1, 10'd9);  wait_idle();
    issue(OP_DELETE, 10'd300, 10'd1, 10'd2, 1'b1, 10'd300, 1'b0, 1'b0, 2'd0, 10'd300); wait_idle();
    issue(OP_INSERT, 10'd5, 10'd5, 10'd9,  1'b0, 10'd0,  1'b0, 1'b0, 2'd3, 10'd5);  wait_idle();
    issue(OP_INSERT, 10'd1023, 10'd1023, 10'd0, 1'b1, 10'd1023, 1'b1, 1'b1, 2'd0, 10'd1023); wait_idle();

    // Back-pressure: response held for five cycles.
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    issue(OP_INSERT, 10'd7, 10'd7, 10'd8, 1'b1, 10'd7, 1'b1, 1'b1, 2'd0, 10'd7);
    for (int i = 0; i < 5; i++) begin
      chk("hold_resp_valid", bus.resp_valid, 32'd1);
      chk("hold_req_ready",  bus.req_ready,  32'd0);
      chk("hold_resp_ok",    bus.resp_ok,    32'd1);
      chk("hold_resp_sel",   bus.resp_sel,   32'd0);
      chk("hold_resp_adr",   bus.resp_adr,   32'd7);
      if (i < 4) @(negedge clk);
    end
    @(posedge clk); #1;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    chk("hold_release_req_ready", bus.req_ready, 32'd0);
    @(negedge clk);
    chk("after_hold_req_ready",  bus.req_ready,  32'd1);
    chk("after_hold_resp_valid", bus.resp_valid, 32'd0);

    // Reset arriving while the insert sits in CHK drops its write.
    @(posedge clk); #1;
    bus.req_op = OP_INSERT; bus.req_adr_0 = 10'd100; bus.req_adr_1 = 10'd101; bus.req_adr_2 = 10'd102;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("chk_rst_write_en",   bus.write_en,   32'd0);
    chk("chk_rst_req_ready",  bus.req_ready,  32'd0);
    chk("chk_rst_resp_valid", bus.resp_valid, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_resp_sel",   bus.resp_sel,   32'd3);
    chk("post_rst_resp_adr",   bus.resp_adr,   32'd0);
    chk("post_rst_resp_ok",    bus.resp_ok,    32'd0);
    chk("post_rst_read_adr_0", bus.read_adr_0, 32'd0);
    chk("post_rst_req_ready",  bus.req_ready,  32'd1);
    chk("post_rst_flag_100",   flags[100],     32'd0);
    issue(OP_INSERT, 10'd100, 10'd101, 10'd102, 1'b1, 10'd100, 1'b1, 1'b1, 2'd0, 10'd100); wait_idle();

    repeat (3) @(negedge clk);
    chk("resp_q_drained",  resp_q.size(), 32'd0);
    chk("write_q_drained", wr_q.size(),   32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/second_chance_slot_allocator.md
Name: second_chance_slot_allocator

Overview:
- Control stage directly upstream of the second-chance flag register.
- Accepts insert/delete requests carrying three candidate hash addresses and drives the flag register's three read ports.
- Evaluates the returned valid flags, picks the first free candidate (priority 0 > 1 > 2), and issues the flag write.
- Returns the chosen slot to the requester through a valid/ready response.

Parameters:
- SIZE, 10, address width of the flag space (2**SIZE slots); must match the flag register's SIZE.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request (high only in IDLE, never during reset)
- req_op  input  1  0 = insert, 1 = delete
- req_adr_0  input  SIZE  candidate address from hash 0 (also the delete address)
- req_adr_1  input  SIZE  candidate address from hash 1 (ignored on delete)
- req_adr_2  input  SIZE  candidate address from hash 2 (ignored on delete)
- read_adr_0  output  SIZE  to flag register read port 0
- read_adr_1  output  SIZE  to flag register read port 1
- read_adr_2  output  SIZE  to flag register read port 2
- flag_in_0  input  1  registered flag from read port 0 (1-cycle latency)
- flag_in_1  input  1  registered flag from read port 1
- flag_in_2  input  1  registered flag from read port 2
- write_adr  output  SIZE  flag register write address
- write_en  output  1  flag register write strobe
- write_is_valid  output  1  value written: 1 on insert, 0 on delete
- resp_valid  output  1  response available
- resp_ready  input  1  consumer accepts response
- resp_ok  output  1  insert: a slot was allocated; delete: the slot was previously valid
- resp_sel  output  2  insert: winning candidate 0/1/2 (3 = none); delete: 0
- resp_adr  output  SIZE  allocated or deleted address

Behaviour:
- Reset: state IDLE; req_ready=0 during the reset cycle; resp_valid=0, resp_ok=0, resp_sel=3, resp_adr=0; write_en=0; read_adr_* and latched request = 0. A pending write in CHK is dropped: write_en is gated by !reset.
- States: IDLE -> RD -> CHK -> RSP -> IDLE.
- IDLE: req_ready=1. On req_valid&&req_ready, latch op and the three addresses; go to RD.
- read_adr_0..2 are driven from the latched addresses in every state.
- RD: one cycle while the flag register samples. Go to CHK unconditionally.
- CHK, insert: free_i = !flag_in_i.
  - Winner is the lowest i with free_i.
  - If a winner exists: write_en=1, write_adr=latched adr_i, write_is_valid=1; register resp_ok=1, resp_sel=i, resp_adr=adr_i.
  - If no winner: write_en=0; resp_ok=0, resp_sel=3, resp_adr=latched adr_0.
  - Go to RSP.
- CHK, delete: write_en=1, write_adr=latched adr_0, write_is_valid=0; resp_ok=flag_in_0, resp_sel=0, resp_adr=adr_0. Go to RSP.
- write_en, write_adr and write_is_valid are combinational from state CHK. The write lands on the edge that leaves CHK.
- RSP: resp_valid=1, and response fields are held stable until resp_valid&&resp_ready. On that edge go to IDLE.
- Latency:
  - Accept edge T0; flags sampled at T1; write and response registered at T2.
  - resp_valid is high in the cycle after T2.
  - Minimum 4 cycles per request, with resp_ready tied high.
- Coherence: the next request reads only after the previous write has landed, so no bypass is needed.
- Duplicate candidates (e.g. adr_0==adr_1): handled naturally; the lowest index wins.
- Address wrap: none. Addresses are used as given, full SIZE bits.

Optional Feature:
- Macro: SLOT_ALLOC_STATS_EN.
- When defined, adds the following outputs, each cleared by reset:
  - stat_inserts (32 bits): +1 per successful insert write.
  - stat_fails (32 bits): +1 per insert with no free candidate.
  - stat_occupied (SIZE+1 bits): +1 on successful insert; -1 on delete with resp_ok=1; saturating at 0 and 2**SIZE.
- Counters update on the CHK exit edge.
- When undefined: no stat ports and no counter logic.

Decomposition:
- Shared package second_chance_pkg:
  - op enum (OP_INSERT=0, OP_DELETE=1);
  - state enum;
  - constant SEL_NONE=2'd3.
- One natural sub-module: second_chance_free_select, a combinational 3-input priority picker returning found and sel.

Test Plan:
- Reset, then insert adr (5,9,12), all flags 0 -> write_en at T2 with write_adr=5, write_is_valid=1; resp_ok=1, resp_sel=0, resp_adr=5.
- Repeat insert (5,9,12) -> slot 5 is now valid; write_adr=9, resp_sel=1. A third repeat gives resp_sel=2, adr 12.
- Fourth insert (5,9,12) -> no write_en; resp_ok=0, resp_sel=3, resp_adr=5.
- Delete adr 9 -> write_adr=9, write_is_valid=0, resp_ok=1. A following insert (5,9,12) allocates 9 with resp_sel=1.
- Hold resp_ready=0 for 5 cycles -> resp fields stable and req_ready=0 throughout. Assert resp_ready -> IDLE next cycle.
- Assert reset while in CHK -> write_en=0 in that cycle; all outputs at reset values; flag state unchanged.
